// File: rtl/dmem_responder.sv
// Data-memory target for the CPU load/store port: word-addressed array with byte-masked
// stores, registered load data, out-of-range flagging and a fixed number of wait states.
module dmem_responder #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                 state, next_state;
    logic [3:0]             cnt;
    logic                   accept;
    logic                   enter_resp;

    logic                   we_q;
    logic [31:2]            addr_q;
    logic [3:0]             be_q;
    logic [31:0]            wdata_q;

    logic                   eff_we;
    logic [31:2]            eff_addr;
    logic [3:0]             eff_be;
    logic [31:0]            eff_wdata;
    logic                   eff_err;
    logic [ADDR_BITS-1:0]   idx;
    logic [1:0]             unused_addr_lsb;

    logic [31:0]            mem [2**ADDR_BITS];

    assign unused_addr_lsb = addr[1:0];
    assign accept          = (state == IDLE) && req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (cnt == 4'd1) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ack  = (state == RESP);
        busy = (state != IDLE);
    end

    assign enter_resp = (next_state == RESP) && (state != RESP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= 4'd0;
        else if (accept)
            cnt <= 4'(WAIT_CYCLES);
        else if (state == WAIT)
            cnt <= cnt - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= we;
            addr_q  <= addr[31:2];
            be_q    <= be;
            wdata_q <= wdata;
        end
    end

    // With zero wait states the commit edge is also the acceptance edge, so the
    // live inputs stand in for the latched copy while still in IDLE.
    always_comb begin
        if (state == IDLE) begin
            eff_we    = we;
            eff_addr  = addr[31:2];
            eff_be    = be;
            eff_wdata = wdata;
        end else begin
            eff_we    = we_q;
            eff_addr  = addr_q;
            eff_be    = be_q;
            eff_wdata = wdata_q;
        end
        idx     = eff_addr[ADDR_BITS+1:2];
        eff_err = (eff_addr[31:ADDR_BITS+2] != '0) || (eff_we && (eff_be == 4'b0000));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= 32'd0;
            err   <= 1'b0;
        end else if (enter_resp) begin
            err <= eff_err;
            if (eff_err)
                rdata <= 32'd0;
            else if (!eff_we)
                rdata <= mem[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (enter_resp && eff_we && !eff_err) begin
            for (int i = 0; i < 4; i++) begin
                if (eff_be[i])
                    mem[idx][8*i +: 8] <= eff_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        ack, err, busy;
    logic [31:0] rdata;

    logic        req0, we0;
    logic [31:0] addr0, wdata0;
    logic [3:0]  be0;
    logic        ack0, err0, busy0;
    logic [31:0] rdata0;

    int tests = 0;
    int fails = 0;

    logic [31:0] rd;
    logic        e;
    int          lat;
    int          a1, a2, nack;

    dmem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .be(be),
        .wdata(wdata), .ack(ack), .rdata(rdata), .err(err), .busy(busy)
    );

    dmem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .be(be0),
        .wdata(wdata0), .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request on the two-wait-state instance; lat = negedges from acceptance to ack.
    task automatic txn(input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input bit corrupt,
                       output logic [31:0] r, output logic er, output int l);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        @(posedge clk);
        l = 99;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (corrupt && i == 1) begin
                addr = 32'h0; wdata = 32'hFFFF_FFFF; be = 4'hF; we = ~w;
            end
            if (ack) begin
                l = i;
                break;
            end
        end
        r   = rdata;
        er  = err;
        req = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req = 0; we = 0; addr = 0; be = 0; wdata = 0;
        req0 = 0; we0 = 0; addr0 = 0; be0 = 0; wdata0 = 0;
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;

        // T1
        txn(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0, rd, e, lat);
        chk("t1_st_lat", lat, 3);
        chk("t1_st_err", {31'd0, e}, 32'd0);
        @(negedge clk);
        chk("t1_ack_pulse", {31'd0, ack}, 32'd0);
        txn(1'b0, 32'h10, 4'h0, 32'h0, 1'b0, rd, e, lat);
        chk("t1_ld_lat", lat, 3);
        chk("t1_ld_data", rd, 32'hDEAD_BEEF);

        // T2
        txn(1'b1, 32'h10, 4'b0010, 32'h0000_AB00, 1'b0, rd, e, lat);
        chk("t2_st_rdata_held", rd, 32'hDEAD_BEEF);
        txn(1'b0, 32'h10, 4'h0, 32'h0, 1'b0, rd, e, lat);
        chk("t2_ld_data", rd, 32'hDEAD_ABEF);

        // T3
        txn(1'b1, 32'h0, 4'hF, 32'h0102_0304, 1'b0, rd, e, lat);
        txn(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, rd, e, lat);
        chk("t3_ld0_pre", rd, 32'h0102_0304);
        txn(1'b1, 32'h0000_1000, 4'hF, 32'h9999_9999, 1'b0, rd, e, lat);
        chk("t3_oor_err", {31'd0, e}, 32'd1);
        chk("t3_oor_rdata", rd, 32'd0);
        chk("t3_oor_lat", lat, 3);
        txn(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, rd, e, lat);
        chk("t3_ld0_post", rd, 32'h0102_0304);
        chk("t3_ld0_err", {31'd0, e}, 32'd0);
        txn(1'b1, 32'h10, 4'h0, 32'h7777_7777, 1'b0, rd, e, lat);
        chk("t3_be0_err", {31'd0, e}, 32'd1);
        txn(1'b0, 32'h10, 4'h0, 32'h0, 1'b0, rd, e, lat);
        chk("t3_be0_nowrite", rd, 32'hDEAD_ABEF);

        // T4
        txn(1'b1, 32'h40, 4'hF, 32'hA5A5_A5A5, 1'b1, rd, e, lat);
        txn(1'b0, 32'h40, 4'h0, 32'h0, 1'b0, rd, e, lat);
        chk("t4_latched_store", rd, 32'hA5A5_A5A5);
        txn(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, rd, e, lat);
        chk("t4_no_stray_store", rd, 32'h0102_0304);

        // T5
        txn(1'b1, 32'h20, 4'hF, 32'h1122_3344, 1'b0, rd, e, lat);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h20; be = 4'hF; wdata = 32'h5555_6666;
        @(posedge clk);
        @(negedge clk);
        chk("t5_busy_wait", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        req   = 1'b0;
        #1;
        chk("t5_rst_ack", {31'd0, ack}, 32'd0);
        chk("t5_rst_rdata", rdata, 32'd0);
        chk("t5_rst_err", {31'd0, err}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        nack  = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack) nack++;
        end
        chk("t5_no_ack", nack, 0);
        txn(1'b0, 32'h20, 4'h0, 32'h0, 1'b0, rd, e, lat);
        chk("t5_not_committed", rd, 32'h1122_3344);

        // T6
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h10; be = 4'h0;
        @(posedge clk);
        a1 = -1; a2 = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ack) begin
                if (a1 < 0) a1 = i;
                else begin
                    a2 = i;
                    req = 1'b0;
                    break;
                end
            end
        end
        req = 1'b0;
        chk("t6_first_ack", a1, 3);
        chk("t6_ack_spacing", a2 - a1, 4);
        chk("t6_rdata", rdata, 32'hDEAD_ABEF);

        // Zero wait states
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h4; be0 = 4'hF; wdata0 = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        chk("w0_st_ack", {31'd0, ack0}, 32'd1);
        chk("w0_st_busy", {31'd0, busy0}, 32'd1);
        chk("w0_st_err", {31'd0, err0}, 32'd0);
        req0 = 1'b0;
        @(negedge clk);
        chk("w0_ack_pulse", {31'd0, ack0}, 32'd0);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h4; be0 = 4'h0;
        @(posedge clk);
        @(negedge clk);
        chk("w0_ld_ack", {31'd0, ack0}, 32'd1);
        chk("w0_ld_data", rdata0, 32'hCAFE_F00D);
        req0 = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
